// File: rtl/hazard_scoreboard_if.sv
// Decode / writeback / kill bundle between the pipeline and the hazard scoreboard.
interface hazard_scoreboard_if #(
  parameter int NREG = 32
);
  localparam int IW = $clog2(NREG);

  logic          d_valid;
  logic [IW-1:0] d_rs1;
  logic [IW-1:0] d_rs2;
  logic          d_rs1_used;
  logic          d_rs2_used;
  logic [IW-1:0] d_dst;
  logic          d_we;
  logic          d_muldiv;
  logic          mdu_busy;
  logic          wb_valid;
  logic          wb_we;
  logic [IW-1:0] wb_dst;
  logic          kill_valid;
  logic          kill_we;
  logic [IW-1:0] kill_dst;
  logic          stall;
  logic [1:0]    forwardingAA;
  logic [1:0]    forwardingBB;
  logic          issue;
  logic [NREG-1:0] pending;
  logic          sb_err;

  modport master (
    output d_valid, d_rs1, d_rs2, d_rs1_used, d_rs2_used, d_dst, d_we, d_muldiv,
           mdu_busy, wb_valid, wb_we, wb_dst, kill_valid, kill_we, kill_dst,
    input  stall, forwardingAA, forwardingBB, issue, pending, sb_err
  );

  modport slave (
    input  d_valid, d_rs1, d_rs2, d_rs1_used, d_rs2_used, d_dst, d_we, d_muldiv,
           mdu_busy, wb_valid, wb_we, wb_dst, kill_valid, kill_we, kill_dst,
    output stall, forwardingAA, forwardingBB, issue, pending, sb_err
  );
endinterface

// File: rtl/hazard_scoreboard.sv
// Per-register in-flight writer scoreboard: decides issue/stall/WB-bypass for the
// decode-stage instruction and gates entry into the shared mul/div unit.
module hazard_scoreboard #(
  parameter int NREG  = 32,
  parameter int CNT_W = 2
) (
  input  logic               clk,
  input  logic               reset,
  hazard_scoreboard_if.slave sb
);
  localparam int IW = $clog2(NREG);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] cnt     [NREG];
  logic [CNT_W-1:0] cnt_nxt [NREG];
  logic             sb_err;
  logic             underflow;
  logic             hazard;
  logic [1:0]       fwd_a;
  logic [1:0]       fwd_b;
  logic             wb_act;
  logic             kill_act;
  logic             live;

  assign wb_act   = sb.wb_valid & sb.wb_we;
  assign kill_act = sb.kill_valid & sb.kill_we;
  // Outputs are forced quiet while reset is held, even if decode is presenting work.
  assign live     = reset & sb.d_valid;

  always_comb begin
    hazard = 1'b0;
    fwd_a  = 2'd0;
    fwd_b  = 2'd0;
    if (sb.d_rs1_used && sb.d_rs1 != '0 && cnt[sb.d_rs1] != '0) begin
      if (cnt[sb.d_rs1] == CNT_W'(1) && wb_act && sb.wb_dst == sb.d_rs1)
        fwd_a = 2'd1;
      else
        hazard = 1'b1;
    end
    if (sb.d_rs2_used && sb.d_rs2 != '0 && cnt[sb.d_rs2] != '0) begin
      if (cnt[sb.d_rs2] == CNT_W'(1) && wb_act && sb.wb_dst == sb.d_rs2)
        fwd_b = 2'd1;
      else
        hazard = 1'b1;
    end
    if (sb.d_muldiv && sb.mdu_busy)
      hazard = 1'b1;
    // A full counter may still take a new writer if one retires or dies this cycle.
    if (sb.d_we && sb.d_dst != '0 && cnt[sb.d_dst] == CNT_MAX
        && !(wb_act && sb.wb_dst == sb.d_dst)
        && !(kill_act && sb.kill_dst == sb.d_dst))
      hazard = 1'b1;
  end

  assign sb.stall        = live & hazard;
  assign sb.issue        = live & ~hazard;
  assign sb.forwardingAA = live ? fwd_a : 2'd0;
  assign sb.forwardingBB = live ? fwd_b : 2'd0;
  assign sb.sb_err       = sb_err;

  always_comb begin
    logic           inc;
    logic           dec_w;
    logic           dec_k;
    logic [CNT_W:0] up;
    logic [CNT_W:0] down;
    logic [CNT_W:0] diff;
    inc       = 1'b0;
    dec_w     = 1'b0;
    dec_k     = 1'b0;
    up        = '0;
    down      = '0;
    diff      = '0;
    underflow = 1'b0;
    cnt_nxt[0] = '0;
    for (int r = 1; r < NREG; r++) begin
      inc   = sb.issue & sb.d_we & (sb.d_dst == IW'(r));
      dec_w = wb_act & (sb.wb_dst == IW'(r));
      dec_k = kill_act & (sb.kill_dst == IW'(r));
      up    = {1'b0, cnt[r]} + (CNT_W+1)'(inc);
      down  = (CNT_W+1)'(dec_w) + (CNT_W+1)'(dec_k);
      diff  = up - down;
      if (up < down) begin
        cnt_nxt[r] = '0;
        underflow  = 1'b1;
      end else begin
        cnt_nxt[r] = diff[CNT_W-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int r = 0; r < NREG; r++)
        cnt[r] <= '0;
      sb_err <= 1'b0;
    end else begin
      cnt    <= cnt_nxt;
      sb_err <= sb_err | underflow;
    end
  end

  for (genvar g = 0; g < NREG; g++) begin : g_pend
    assign sb.pending[g] = (cnt[g] != '0);
  end
endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
- Per-register scoreboard that schedules issue from decode into execute.
- Counts in-flight writers per architectural register.
- Each cycle, decides whether the decode-stage instruction may issue, stalls, or takes its operand from the writeback result. Drives the decode stage's `stall` and `forwardingAA`/`forwardingBB` selects.
- Also gates issue into the shared multi-cycle mul/div unit.

Parameters:
- NREG, 32, number of architectural registers (index width = $clog2(NREG)).
- CNT_W, 2, width of each in-flight-writer counter; max count = 2**CNT_W-1.

Ports:
- clk  input  1  clock
- reset  input  1  asynchronous, active-low reset
- d_valid  input  1  decode holds a valid instruction
- d_rs1, d_rs2  input  5 each  source register indices
- d_rs1_used, d_rs2_used  input  1 each  source actually read
- d_dst  input  5  destination index
- d_we  input  1  instruction writes d_dst
- d_muldiv  input  1  instruction uses the mul/div unit
- mdu_busy  input  1  mul/div unit cannot accept work
- wb_valid  input  1  writeback retiring an instruction
- wb_we, wb_dst  input  1, 5  writeback write enable and index
- kill_valid  input  1  instruction in execute squashed this cycle
- kill_we, kill_dst  input  1, 5  squashed instruction's write info
- stall  output  1  hold decode; no issue this cycle
- forwardingAA, forwardingBB  output  2 each  0 = regfile, 1 = WB data; 2/3 never driven
- issue  output  1  d_valid & ~stall
- pending  output  NREG  bit i = cnt[i] != 0
- sb_err  output  1  sticky underflow error

Behaviour:
- Reset (reset=0, async):
  - All cnt[i] = 0 and sb_err = 0.
  - Outputs: stall=0, issue=0, forwarding=0, pending=0.
  - Asserting reset mid-operation discards all tracking immediately.
- Register 0:
  - Never tracked; cnt[0] stays 0.
  - A source of x0 never hazards; its forwarding select = 0.
- Source hazard for rsN (N = 1, 2), evaluated only when rsN_used and rsN != 0:
  - cnt[rsN]==0 → select 0, no stall.
  - cnt[rsN]==1 and wb_valid & wb_we & wb_dst==rsN this cycle → select 1, no stall (same-cycle WB bypass).
  - Otherwise → stall.
- Structural stall:
  - d_muldiv & mdu_busy.
  - d_we & d_dst!=0 & cnt[d_dst]==max & no WB/kill of d_dst this cycle (counter full).
- Output logic:
  - stall = d_valid & (any hazard); combinational, same cycle.
  - When d_valid=0: stall=0 and forwarding=0.
- Counter update at posedge, per register r, net delta applied once:
  - +1 if issue & d_we & d_dst==r.
  - −1 if wb_valid & wb_we & wb_dst==r.
  - −1 if kill_valid & kill_we & kill_dst==r.
  - Issue, WB and kill on the same register in the same cycle sum correctly (e.g. +1−1 = unchanged).
- Underflow:
  - A decrement on cnt==0 leaves cnt at 0 and sets sb_err; sb_err stays 1 until reset.
  - Applies to a −1 from WB or from kill.
- Stalled instructions never increment a counter.
- A kill and a WB of different registers in the same cycle are both applied.
- Latency: hazard decisions are 0-cycle (combinational); counter effects are visible the next cycle.

Test Plan:
- Reset, then issue `addi x5` (d_we=1, d_dst=5) → next cycle pending[5]=1. Then instruction reading rs1=5 with no WB → stall=1, issue=0. On the cycle wb_dst=5 → stall=0, forwardingAA=1. Next cycle pending[5]=0, forwardingAA=0.
- Two back-to-back writers of x7 (cnt=2). Reader of x7 while the first WB of x7 occurs → stall=1, no forwarding. After the second WB → stall=0, forwardingAA=1.
- In one cycle: issue writes x3, WB retires x3 (cnt was 1), kill on x9 (cnt was 1) → next cycle cnt[3]=1, cnt[9]=0, sb_err=0.
- d_muldiv=1 with mdu_busy=1 for 10 cycles → stall=1 throughout. mdu_busy→0 → issue=1 the same cycle.
- Three issues to x4 with CNT_W=2 (cnt=3), fourth writer to x4 → stall=1. wb_dst=4 that cycle → issue=1 and cnt stays 3.
- WB of x12 with cnt[12]=0 → sb_err=1 and stays set. Async reset asserted mid-stall → stall=0, pending=0 and sb_err=0 immediately, without waiting for a clock edge.
